// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS datapath: ALU operation codes, main-control
// aluop codes and the R-type funct values the ALU control understands.
package mips_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_REG_AW = 5;

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_SUB = 4'b0110,
    OP_SLT = 4'b0111,
    OP_NOR = 4'b1100
  } alu_operation_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_RSVD  = 2'b11
  } alu_op_e;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;

endpackage

// File: rtl/alu_control.sv
// Combinational ALU control: maps the main-control aluop and the R-type funct
// field onto the 4-bit alu operation, flagging unsupported funct values.
module alu_control
  import mips_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] operation,
  output logic       illegal
);

  always_comb begin
    operation = OP_ADD;
    illegal   = 1'b0;
    case (alu_op)
      ALUOP_SUB: operation = OP_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_ADD: operation = OP_ADD;
          FUNCT_SUB: operation = OP_SUB;
          FUNCT_AND: operation = OP_AND;
          FUNCT_OR:  operation = OP_OR;
          FUNCT_SLT: operation = OP_SLT;
          FUNCT_NOR: operation = OP_NOR;
          default: begin
            operation = OP_ADD;
            illegal   = 1'b1;
          end
        endcase
      end
      // The reserved aluop behaves like a plain add.
      default: operation = OP_ADD;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: decodes ALU control, registers the instruction,
// forwards operands from EX/MEM and MEM/WB and detects load-use hazards.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [1:0]        id_alu_op,
  input  logic [5:0]        id_funct,
  input  logic              id_alu_src,
  input  logic              id_reg_dst,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic              id_branch,
  input  logic              stall,
  input  logic              flush,
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_write,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  output logic              hazard_stall,
  output logic              ex_valid,
  output logic [3:0]        ex_operation,
  output logic [DATA_W-1:0] ex_operand_a,
  output logic [DATA_W-1:0] ex_operand_b,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_AW-1:0] ex_dest_reg,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic              ex_branch,
  output logic              ex_illegal_funct
);

  logic [3:0]        dec_operation;
  logic              dec_illegal;
  logic              id_uses_rt;

  logic              valid_q;
  logic [3:0]        operation_q;
  logic              illegal_q;
  logic [REG_AW-1:0] rs_q;
  logic [REG_AW-1:0] rt_q;
  logic [REG_AW-1:0] dest_q;
  logic [DATA_W-1:0] rs_data_q;
  logic [DATA_W-1:0] rt_data_q;
  logic [DATA_W-1:0] imm_q;
  logic              alu_src_q;
  logic              reg_write_q;
  logic              mem_read_q;
  logic              mem_write_q;
  logic              mem_to_reg_q;
  logic              branch_q;

  logic [DATA_W-1:0] fwd_rs;
  logic [DATA_W-1:0] fwd_rt;

  alu_control u_alu_control (
    .alu_op    (id_alu_op),
    .funct     (id_funct),
    .operation (dec_operation),
    .illegal   (dec_illegal)
  );

  assign id_uses_rt   = (id_alu_op == ALUOP_FUNCT) | id_mem_write | id_branch;
  assign hazard_stall = id_valid & valid_q & mem_read_q & (rt_q != '0) &
                        ((rt_q == id_rs) | ((rt_q == id_rt) & id_uses_rt));

  // Bubbles clear only control state; the data fields keep their last
  // captured values. A non-valid ID slot is captured as a bubble too, so
  // downstream never sees stray write/memory enables.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q      <= 1'b0;
      operation_q  <= '0;
      illegal_q    <= 1'b0;
      rs_q         <= '0;
      rt_q         <= '0;
      dest_q       <= '0;
      rs_data_q    <= '0;
      rt_data_q    <= '0;
      imm_q        <= '0;
      alu_src_q    <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      branch_q     <= 1'b0;
    end else if (flush || (!stall && hazard_stall)) begin
      valid_q      <= 1'b0;
      operation_q  <= '0;
      illegal_q    <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      branch_q     <= 1'b0;
    end else if (!stall) begin
      valid_q      <= id_valid;
      operation_q  <= id_valid ? dec_operation : 4'b0000;
      illegal_q    <= id_valid & dec_illegal;
      rs_q         <= id_rs;
      rt_q         <= id_rt;
      dest_q       <= id_reg_dst ? id_rd : id_rt;
      rs_data_q    <= id_rs_data;
      rt_data_q    <= id_rt_data;
      imm_q        <= id_imm;
      alu_src_q    <= id_alu_src;
      reg_write_q  <= id_valid & id_reg_write;
      mem_read_q   <= id_valid & id_mem_read;
      mem_write_q  <= id_valid & id_mem_write;
      mem_to_reg_q <= id_valid & id_mem_to_reg;
      branch_q     <= id_valid & id_branch;
    end
  end

  // The younger EX/MEM result wins over MEM/WB; register 0 is hard-wired zero.
  assign fwd_rs = (exmem_reg_write && exmem_rd != '0 && exmem_rd == rs_q) ? exmem_result :
                  (memwb_reg_write && memwb_rd != '0 && memwb_rd == rs_q) ? memwb_result :
                  rs_data_q;
  assign fwd_rt = (exmem_reg_write && exmem_rd != '0 && exmem_rd == rt_q) ? exmem_result :
                  (memwb_reg_write && memwb_rd != '0 && memwb_rd == rt_q) ? memwb_result :
                  rt_data_q;

  assign ex_valid         = valid_q;
  assign ex_operation     = operation_q;
  assign ex_operand_a     = fwd_rs;
  assign ex_operand_b     = alu_src_q ? imm_q : fwd_rt;
  assign ex_store_data    = fwd_rt;
  assign ex_dest_reg      = dest_q;
  assign ex_reg_write     = reg_write_q;
  assign ex_mem_read      = mem_read_q;
  assign ex_mem_write     = mem_write_q;
  assign ex_mem_to_reg    = mem_to_reg_q;
  assign ex_branch        = branch_q;
  assign ex_illegal_funct = illegal_q;

endmodule
